// File: rtl/flow_ctrl_fsm_if.sv
// Signal bundle between the FIFO bank environment (master) and the flow-control supervisor (slave).
// Optional FLOW_CTRL_CH_MASK_EN adds the ch_mask configuration input.
interface flow_ctrl_fsm_if #(
  parameter int NUM_CH = 8,
  parameter int TH_W   = 3
);
  // No valid/ready pairs here: every input is a level sampled on each rising edge,
  // and every output is a registered level that is valid on every cycle.
  logic              init;
  logic [TH_W-1:0]   th_low_in;
  logic [TH_W-1:0]   th_high_in;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_err;
  logic              err_clear;
`ifdef FLOW_CTRL_CH_MASK_EN
  logic [NUM_CH-1:0] ch_mask;
`endif

  logic [2:0]        state;
  logic              idle;
  logic              active;
  logic              err;
  logic              cfg_err;
  logic [TH_W-1:0]   th_low;
  logic [TH_W-1:0]   th_high;
  logic [NUM_CH-1:0] err_ch;

  modport master (
`ifdef FLOW_CTRL_CH_MASK_EN
    output ch_mask,
`endif
    output init, th_low_in, th_high_in, fifo_empty, fifo_err, err_clear,
    input  state, idle, active, err, cfg_err, th_low, th_high, err_ch
  );

  modport slave (
`ifdef FLOW_CTRL_CH_MASK_EN
    input  ch_mask,
`endif
    input  init, th_low_in, th_high_in, fifo_empty, fifo_err, err_clear,
    output state, idle, active, err, cfg_err, th_low, th_high, err_ch
  );
endinterface

// File: rtl/flow_ctrl_fsm.sv
// Flow-control supervisor: captures/validates thresholds, tracks FIFO occupancy, latches FIFO errors.
// Optional FLOW_CTRL_CH_MASK_EN: per-channel mask committed with the thresholds.
module flow_ctrl_fsm #(
  parameter int NUM_CH   = 8,
  parameter int TH_W     = 3,
  parameter int IDLE_DLY = 2
) (
  input logic           clk,
  input logic           reset,
  flow_ctrl_fsm_if.slave bus
);
  localparam int               CNT_W    = $clog2(IDLE_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_DLY - 1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t            state_q;
  logic              idle_q, active_q, err_q, cfg_err_q;
  logic [TH_W-1:0]   sh_low, sh_high, th_low_q, th_high_q;
  logic [NUM_CH-1:0] err_ch_q;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] eff_empty, eff_err;
  logic              all_empty, any_err;

`ifdef FLOW_CTRL_CH_MASK_EN
  logic [NUM_CH-1:0] sh_mask, mask_q;
  // Masked channels look permanently empty and never report errors.
  assign eff_empty = bus.fifo_empty | mask_q;
  assign eff_err   = bus.fifo_err & ~mask_q;
`else
  assign eff_empty = bus.fifo_empty;
  assign eff_err   = bus.fifo_err;
`endif

  assign all_empty = &eff_empty;
  assign any_err   = |eff_err;

  // The idle/active/err flags are written on every transition together with the
  // state register, so they always describe the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RESET;
      idle_q    <= 1'b0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      sh_low    <= '0;
      sh_high   <= '0;
      th_low_q  <= '0;
      th_high_q <= '0;
      err_ch_q  <= '0;
      cnt       <= '0;
`ifdef FLOW_CTRL_CH_MASK_EN
      sh_mask   <= '0;
      mask_q    <= '0;
`endif
    end else begin
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_RESET: begin
          state_q <= ST_INIT;
          cnt     <= '0;
        end
        ST_INIT: begin
          cnt <= '0;
          if (bus.init) begin
            sh_low  <= bus.th_low_in;
            sh_high <= bus.th_high_in;
`ifdef FLOW_CTRL_CH_MASK_EN
            sh_mask <= bus.ch_mask;
`endif
          end else if (sh_low < sh_high) begin
            th_low_q  <= sh_low;
            th_high_q <= sh_high;
`ifdef FLOW_CTRL_CH_MASK_EN
            mask_q    <= sh_mask;
`endif
            cfg_err_q <= 1'b0;
            state_q   <= ST_IDLE;
            idle_q    <= 1'b1;
          end else begin
            cfg_err_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          cnt <= '0;
          if (any_err) begin
            state_q  <= ST_ERROR;
            err_q    <= 1'b1;
            err_ch_q <= err_ch_q | eff_err;
          end else if (bus.init) begin
            state_q <= ST_INIT;
          end else if (!all_empty) begin
            state_q  <= ST_ACTIVE;
            active_q <= 1'b1;
          end else begin
            idle_q <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (any_err) begin
            state_q  <= ST_ERROR;
            err_q    <= 1'b1;
            err_ch_q <= err_ch_q | eff_err;
            cnt      <= '0;
          end else if (bus.init) begin
            state_q <= ST_INIT;
            cnt     <= '0;
          end else if (all_empty) begin
            // Hysteresis: leave only on the IDLE_DLY-th consecutive all-empty cycle.
            if (cnt >= CNT_LAST) begin
              state_q <= ST_IDLE;
              idle_q  <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt      <= cnt + 1'b1;
              active_q <= 1'b1;
            end
          end else begin
            cnt      <= '0;
            active_q <= 1'b1;
          end
        end
        ST_ERROR: begin
          cnt <= '0;
          if (bus.err_clear) begin
            state_q  <= ST_IDLE;
            idle_q   <= 1'b1;
            err_ch_q <= '0;
          end else begin
            err_q    <= 1'b1;
            err_ch_q <= err_ch_q | eff_err;
          end
        end
        default: begin
          state_q <= ST_RESET;
          cnt     <= '0;
        end
      endcase
    end
  end

  assign bus.state   = state_q;
  assign bus.idle    = idle_q;
  assign bus.active  = active_q;
  assign bus.err     = err_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.th_low  = th_low_q;
  assign bus.th_high = th_high_q;
  assign bus.err_ch  = err_ch_q;
endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Bench for flow_ctrl_fsm: directed scenarios plus random steps, checked against a cycle model.
module tb_flow_ctrl_fsm;
  localparam int NUM_CH   = 8;
  localparam int TH_W     = 3;
  localparam int IDLE_DLY = 2;
  localparam int W        = 3 + 4 + 2*TH_W + NUM_CH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  flow_ctrl_fsm_if #(.NUM_CH(NUM_CH), .TH_W(TH_W)) bus ();

  flow_ctrl_fsm #(.NUM_CH(NUM_CH), .TH_W(TH_W), .IDLE_DLY(IDLE_DLY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0]        m_state;
  logic              m_cfg;
  logic [TH_W-1:0]   m_tl, m_th, m_sl, m_sh;
  logic [NUM_CH-1:0] m_errch;
  int                m_cnt;

  task automatic model_step();
    if (reset) begin
      m_state = 0; m_cfg = 0; m_tl = 0; m_th = 0; m_sl = 0; m_sh = 0; m_errch = 0; m_cnt = 0;
    end else begin
      case (m_state)
        3'd0: m_state = 3'd1;
        3'd1: begin
          if (bus.init) begin
            m_sl = bus.th_low_in; m_sh = bus.th_high_in;
          end else if (m_sl < m_sh) begin
            m_tl = m_sl; m_th = m_sh; m_cfg = 0; m_state = 3'd2;
          end else m_cfg = 1;
        end
        3'd2: begin
          if (|bus.fifo_err) begin m_state = 3'd4; m_errch |= bus.fifo_err; end
          else if (bus.init) m_state = 3'd1;
          else if (!(&bus.fifo_empty)) begin m_state = 3'd3; m_cnt = 0; end
        end
        3'd3: begin
          if (|bus.fifo_err) begin m_state = 3'd4; m_errch |= bus.fifo_err; end
          else if (bus.init) m_state = 3'd1;
          else if (&bus.fifo_empty) begin
            m_cnt++;
            if (m_cnt == IDLE_DLY) m_state = 3'd2;
          end else m_cnt = 0;
        end
        3'd4: begin
          if (bus.err_clear) begin m_state = 3'd2; m_errch = 0; end
          else m_errch |= bus.fifo_err;
        end
        default: m_state = 3'd0;
      endcase
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    return {m_state, m_state == 3'd2, m_state == 3'd3, m_state == 3'd4, m_cfg, m_tl, m_th, m_errch};
  endfunction

  function automatic logic [W-1:0] dut_pack();
    return {bus.state, bus.idle, bus.active, bus.err, bus.cfg_err, bus.th_low, bus.th_high, bus.err_ch};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic rst, input logic ini,
                      input logic [TH_W-1:0] lo, input logic [TH_W-1:0] hi,
                      input logic [NUM_CH-1:0] emp, input logic [NUM_CH-1:0] ferr,
                      input logic clr);
    logic [W-1:0] e;
    @(negedge clk);
    reset          = rst;
    bus.init       = ini;
    bus.th_low_in  = lo;
    bus.th_high_in = hi;
    bus.fifo_empty = emp;
    bus.fifo_err   = ferr;
    bus.err_clear  = clr;
    model_step();
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, dut_pack(), e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
`ifdef FLOW_CTRL_CH_MASK_EN
    bus.ch_mask = '0;
`endif
    bus.init = 0; bus.th_low_in = 0; bus.th_high_in = 0;
    bus.fifo_empty = '1; bus.fifo_err = '0; bus.err_clear = 0;

    // Reset and first configuration 2/5
    step("reset0", 1, 0, 0, 0, 8'hFF, 8'h00, 0);
    step("reset1", 1, 1, 2, 5, 8'hFF, 8'h00, 0);
    check_eq("reset_outputs", dut_pack(), '0);
    step("to_init", 0, 1, 2, 5, 8'hFF, 8'h00, 0);
    check_eq("state_init", W'(bus.state), W'(1));
    step("init_ld1", 0, 1, 2, 5, 8'hFF, 8'h00, 0);
    step("init_ld2", 0, 1, 2, 5, 8'hFF, 8'h00, 0);
    step("init_exit", 0, 0, 2, 5, 8'hFF, 8'h00, 0);
    check_eq("cfg_ok_state", W'(bus.state), W'(2));
    check_eq("cfg_ok_thr", W'({bus.cfg_err, bus.th_low, bus.th_high}), W'({1'b0, 3'd2, 3'd5}));

    // Invalid thresholds 5/5 then retry 1/6
    step("rst_b", 1, 0, 0, 0, 8'hFF, 8'h00, 0);
    step("to_init_b", 0, 1, 5, 5, 8'hFF, 8'h00, 0);
    step("ld_bad", 0, 1, 5, 5, 8'hFF, 8'h00, 0);
    step("exit_bad", 0, 0, 5, 5, 8'hFF, 8'h00, 0);
    check_eq("bad_cfg", W'({bus.state, bus.cfg_err, bus.th_low, bus.th_high}), W'({3'd1, 1'b1, 3'd0, 3'd0}));
    step("ld_good", 0, 1, 1, 6, 8'hFF, 8'h00, 0);
    step("exit_good", 0, 0, 1, 6, 8'hFF, 8'h00, 0);
    check_eq("good_cfg", W'({bus.state, bus.cfg_err, bus.th_low, bus.th_high}), W'({3'd2, 1'b0, 3'd1, 3'd6}));

    // Hysteresis: FE then FF FF
    step("go_active", 0, 0, 0, 0, 8'hFE, 8'h00, 0);
    check_eq("active_flag", W'({bus.state, bus.active}), W'({3'd3, 1'b1}));
    step("empty1", 0, 0, 0, 0, 8'hFF, 8'h00, 0);
    check_eq("still_active", W'(bus.state), W'(3));
    step("empty2", 0, 0, 0, 0, 8'hFF, 8'h00, 0);
    check_eq("back_idle", W'({bus.state, bus.idle}), W'({3'd2, 1'b1}));

    // Counter clear: FF FE FF FF in ACTIVE
    step("go_active2", 0, 0, 0, 0, 8'h7F, 8'h00, 0);
    step("a_ff", 0, 0, 0, 0, 8'hFF, 8'h00, 0);
    step("a_fe", 0, 0, 0, 0, 8'hFE, 8'h00, 0);
    step("a_ff2", 0, 0, 0, 0, 8'hFF, 8'h00, 0);
    check_eq("cnt_cleared", W'(bus.state), W'(3));
    step("a_ff3", 0, 0, 0, 0, 8'hFF, 8'h00, 0);
    check_eq("idle_after_clear", W'(bus.state), W'(2));

    // Error latch, init ignored, clear
    step("go_active3", 0, 0, 0, 0, 8'hFE, 8'h00, 0);
    step("err04", 0, 0, 0, 0, 8'hFE, 8'h04, 0);
    step("err10", 0, 1, 0, 0, 8'hFE, 8'h10, 0);
    check_eq("err_mask", W'({bus.state, bus.err, bus.err_ch}), W'({3'd4, 1'b1, 8'h14}));
    step("err_init", 0, 1, 0, 0, 8'hFF, 8'h00, 0);
    check_eq("err_ign_init", W'(bus.state), W'(4));
    step("err_clr", 0, 0, 0, 0, 8'hFF, 8'h00, 1);
    check_eq("clr_idle", W'({bus.state, bus.err_ch, bus.th_low, bus.th_high}), W'({3'd2, 8'h00, 3'd1, 3'd6}));
    step("err_idle", 0, 1, 0, 0, 8'hFF, 8'h21, 0);
    step("clr_and_err", 0, 0, 0, 0, 8'hFF, 8'h80, 1);
    check_eq("clr_wins", W'({bus.state, bus.err_ch}), W'({3'd2, 8'h00}));

    // Re-init from IDLE with bad values keeps committed thresholds
    step("reinit", 0, 1, 3, 2, 8'hFF, 8'h00, 0);
    step("reinit_ld", 0, 1, 3, 2, 8'hFF, 8'h00, 0);
    step("reinit_bad", 0, 0, 3, 2, 8'hFF, 8'h00, 0);
    check_eq("keep_thr", W'({bus.state, bus.cfg_err, bus.th_low, bus.th_high}), W'({3'd1, 1'b1, 3'd1, 3'd6}));
    step("reinit_ld2", 0, 1, 0, 7, 8'hFF, 8'h00, 0);
    step("reinit_ok", 0, 0, 0, 7, 8'hFF, 8'h00, 0);

    // Reset mid-ACTIVE with errors present
    step("go_active4", 0, 0, 0, 0, 8'h00, 8'h00, 0);
    step("rst_active", 1, 0, 0, 0, 8'h00, 8'hFF, 0);
    check_eq("rst_wins", dut_pack(), '0);

    // Random walk against the model
    for (int i = 0; i < 300; i++) begin
      logic r, n, c;
      logic [TH_W-1:0] lo, hi;
      logic [NUM_CH-1:0] emp, fe;
      r   = ($urandom_range(0, 39) == 0);
      n   = ($urandom_range(0, 5) == 0);
      c   = ($urandom_range(0, 3) == 0);
      lo  = TH_W'($urandom_range(0, 7));
      hi  = TH_W'($urandom_range(0, 7));
      emp = ($urandom_range(0, 2) == 0) ? NUM_CH'($urandom_range(0, 255)) : 8'hFF;
      fe  = ($urandom_range(0, 11) == 0) ? NUM_CH'(1 << $urandom_range(0, 7)) : 8'h00;
      step("rand", r, n, lo, hi, emp, fe, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
